// File: rtl/wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin Wishbone arbiter sharing one slave port between NUM_M masters.
//   A granted master keeps the bus for its whole CYC.
//   A bus watchdog ends a stalled strobe with a one-cycle ERR to that master.
//
// Ports
//   clk, rst          system clock, asynchronous active-low reset
//   m_cyc_i/stb_i/we_i     per-master control, one bit per master
//   m_adr_i/dat_i/sel_i    per-master address/data/select, master k at slice k
//   m_dat_o           shared read data (straight copy of s_dat_i)
//   m_ack_o/m_err_o   per-master ACK and watchdog ERR
//   s_*               slave-side Wishbone port
//   grant_o           registered one-hot grant (zero when idle)
//   timeout_o         one-cycle pulse while the watchdog error is reported
// ----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_M   = 4,
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_M-1:0]       m_cyc_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [NUM_M*ADR_W-1:0] m_adr_i,
    input  logic [NUM_M*32-1:0]    m_dat_i,
    input  logic [NUM_M*4-1:0]     m_sel_i,
    output logic [31:0]            m_dat_o,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [31:0]            s_dat_o,
    input  logic [31:0]            s_dat_i,
    output logic [3:0]             s_sel_o,
    output logic                   s_we_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic                   s_ack_i,
    output logic [NUM_M-1:0]       grant_o,
    output logic                   timeout_o
);

    localparam int IW        = $clog2(NUM_M);
    localparam int WDW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [WDW-1:0] WD_LAST = WD_LAST_I[WDW-1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IW-1:0]    gidx_q,  gidx_d;
    logic [IW-1:0]    last_q,  last_d;
    logic [WDW-1:0]   wd_q,    wd_d;

    // Round-robin pick: first requester strictly after last_q, wrapping.
    logic          req_found;
    logic [IW-1:0] req_idx;
    logic [IW-1:0] cand;

    always_comb begin
        req_found = 1'b0;
        req_idx   = last_q;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            cand = IW'((32'(last_q) + i) % NUM_M);
            if (!req_found && m_cyc_i[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    // Granted master's signals, selected by the registered grant index.
    logic             g_cyc, g_stb, g_we;
    logic [ADR_W-1:0] g_adr;
    logic [31:0]      g_dat;
    logic [3:0]       g_sel;

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (gidx_q == IW'(k)) begin
                g_cyc = m_cyc_i[k];
                g_stb = m_stb_i[k];
                g_we  = m_we_i[k];
                g_adr = m_adr_i[k*ADR_W +: ADR_W];
                g_dat = m_dat_i[k*32 +: 32];
                g_sel = m_sel_i[k*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (req_found) begin
                    state_d          = S_GRANT;
                    gidx_d           = req_idx;
                    grant_d          = '0;
                    grant_d[req_idx] = 1'b1;
                end
            end
            S_GRANT: begin
                // CYC release beats watchdog expiry; ACK beats expiry too.
                if (!g_cyc) begin
                    state_d = S_IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                    wd_d    = '0;
                end else if (TIMEOUT == 0 || s_ack_i || !g_stb) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ERR: begin
                wd_d = '0;
                if (g_cyc) begin
                    state_d = S_GRANT;
                end else begin
                    state_d = S_IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_M - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Outputs are decoded from the registered state, so they fall with reset.
    always_comb begin
        m_dat_o   = s_dat_i;
        m_ack_o   = '0;
        m_err_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        timeout_o = 1'b0;
        grant_o   = grant_q;
        if (state_q == S_GRANT) begin
            s_cyc_o = g_cyc;
            s_stb_o = g_stb;
            s_we_o  = g_we;
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            m_ack_o = grant_q & {NUM_M{s_ack_i}};
        end else if (state_q == S_ERR) begin
            m_err_o   = grant_q;
            timeout_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter (4 masters, 32-bit address, TIMEOUT=8).
//   Inputs change 2 time units after a rising edge; outputs are sampled
//   1-3 units later, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   m_cyc, m_stb, m_we;
    logic [127:0] m_adr, m_dat;
    logic [15:0]  m_sel;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_o, m_err_o;
    logic [31:0]  s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]   s_sel_o;
    logic         s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [3:0]   grant_o;
    logic         timeout_o;

    logic [31:0]  adr_tab [4];
    logic [31:0]  dat_tab [4];
    logic [3:0]   sel_tab [4];

    int vectors     = 0;
    int miscompares = 0;

    wb_rr_arbiter #(.NUM_M(4), .ADR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m_cyc = 4'b1111; m_stb = 4'b1111; m_we = 4'b1111;
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #3;
        vectors++; if (grant_o !== 4'b0000) begin miscompares++; $display("FAIL rst_grant: got %b want 0000", grant_o); end
        vectors++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_slave_ctl: got cyc%b stb%b we%b want 000", s_cyc_o, s_stb_o, s_we_o); end
        vectors++; if (s_adr_o !== 32'h0) begin miscompares++; $display("FAIL rst_adr: got %h want 0", s_adr_o); end
        vectors++; if (m_ack_o !== 4'b0 || m_err_o !== 4'b0 || timeout_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack_err: got ack%b err%b to%b want 0", m_ack_o, m_err_o, timeout_o); end
        vectors++; if (m_dat_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rst_mdat: got %h want deadbeef", m_dat_o); end
        tick;
        vectors++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL rst_hold: got grant%b cyc%b want 0000 0", grant_o, s_cyc_o); end
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
        #1;
        vectors++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL t1_latency: got grant%b cyc%b want 0000 0", grant_o, s_cyc_o); end
        tick;
        vectors++; if (grant_o !== 4'b0001) begin miscompares++; $display("FAIL t1_grant: got %b want 0001", grant_o); end
        vectors++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_we_o !== 1'b1) begin miscompares++; $display("FAIL t1_ctl: got cyc%b stb%b we%b want 111", s_cyc_o, s_stb_o, s_we_o); end
        vectors++; if (s_adr_o !== adr_tab[0] || s_dat_o !== dat_tab[0] || s_sel_o !== sel_tab[0]) begin miscompares++; $display("FAIL t1_pass: got %h %h %h want %h %h %h", s_adr_o, s_dat_o, s_sel_o, adr_tab[0], dat_tab[0], sel_tab[0]); end
        vectors++; if (m_ack_o !== 4'b0000) begin miscompares++; $display("FAIL t1_noack: got %b want 0000", m_ack_o); end
        tick;
        vectors++; if (m_ack_o !== 4'b0000) begin miscompares++; $display("FAIL t1_wait: got %b want 0000", m_ack_o); end
        tick;
        s_ack_i = 1'b1;
        #1;
        vectors++; if (m_ack_o !== 4'b0001) begin miscompares++; $display("FAIL t1_ack: got %b want 0001", m_ack_o); end
        tick;
        s_ack_i = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
        #1;
        vectors++; if (m_ack_o !== 4'b0000 || grant_o !== 4'b0001) begin miscompares++; $display("FAIL t1_release: got ack%b grant%b want 0000 0001", m_ack_o, grant_o); end
        tick;
        vectors++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL t1_idle: got grant%b cyc%b want 0000 0", grant_o, s_cyc_o); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        int unsigned e;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_cyc = 4'b1111; m_stb = 4'b1111; m_we = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            e     = n % 4;
            exp_g = 4'b0001 << e;
            tick;
            vectors++; if (grant_o !== exp_g) begin miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", n, grant_o, exp_g); end
            vectors++; if (s_adr_o !== adr_tab[e]) begin miscompares++; $display("FAIL rr_adr[%0d]: got %h want %h", n, s_adr_o, adr_tab[e]); end
            s_ack_i = 1'b1;
            #1;
            vectors++; if (m_ack_o !== exp_g) begin miscompares++; $display("FAIL rr_ack[%0d]: got %b want %b", n, m_ack_o, exp_g); end
            tick;
            s_ack_i = 1'b0; m_cyc[e] = 1'b0; m_stb[e] = 1'b0;
            tick;
            vectors++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL rr_dead[%0d]: got grant%b cyc%b want 0000 0", n, grant_o, s_cyc_o); end
            m_cyc[e] = 1'b1; m_stb[e] = 1'b1;
        end
        m_cyc = '0; m_stb = '0;
        tick;
    endtask

    task automatic test_no_preempt;
        m_cyc = 4'b0010; m_stb = 4'b0010;
        tick;
        vectors++; if (grant_o !== 4'b0010) begin miscompares++; $display("FAIL np_grant1: got %b want 0010", grant_o); end
        m_cyc = 4'b0110; m_stb = 4'b0110; s_ack_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            vectors++; if (m_ack_o !== 4'b0010 || grant_o !== 4'b0010) begin miscompares++; $display("FAIL np_hold[%0d]: got ack%b grant%b want 0010 0010", n, m_ack_o, grant_o); end
            vectors++; if (s_adr_o !== adr_tab[1]) begin miscompares++; $display("FAIL np_adr[%0d]: got %h want %h", n, s_adr_o, adr_tab[1]); end
            tick;
        end
        m_cyc = 4'b0100; m_stb = 4'b0100; s_ack_i = 1'b0;
        tick;
        vectors++; if (grant_o !== 4'b0000 || m_ack_o !== 4'b0000) begin miscompares++; $display("FAIL np_dead: got grant%b ack%b want 0000 0000", grant_o, m_ack_o); end
        tick;
        vectors++; if (grant_o !== 4'b0100 || s_adr_o !== adr_tab[2]) begin miscompares++; $display("FAIL np_grant2: got %b %h want 0100 %h", grant_o, s_adr_o, adr_tab[2]); end
        m_cyc = '0; m_stb = '0;
        tick;
    endtask

    task automatic test_watchdog;
        m_cyc = 4'b1000; m_stb = 4'b1000; m_we = 4'b0000;
        tick;
        vectors++; if (grant_o !== 4'b1000) begin miscompares++; $display("FAIL wd_grant: got %b want 1000", grant_o); end
        for (int c = 1; c <= 8; c++) begin
            vectors++; if (s_cyc_o !== 1'b1 || m_ack_o !== 4'b0 || m_err_o !== 4'b0 || timeout_o !== 1'b0) begin miscompares++; $display("FAIL wd_wait[%0d]: got cyc%b ack%b err%b to%b want 1 0000 0000 0", c, s_cyc_o, m_ack_o, m_err_o, timeout_o); end
            tick;
        end
        vectors++; if (m_err_o !== 4'b1000 || timeout_o !== 1'b1) begin miscompares++; $display("FAIL wd_err: got err%b to%b want 1000 1", m_err_o, timeout_o); end
        vectors++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_ack_o !== 4'b0) begin miscompares++; $display("FAIL wd_err_bus: got cyc%b stb%b ack%b want 0 0 0000", s_cyc_o, s_stb_o, m_ack_o); end
        vectors++; if (grant_o !== 4'b1000) begin miscompares++; $display("FAIL wd_err_grant: got %b want 1000", grant_o); end
        tick;
        vectors++; if (timeout_o !== 1'b0 || m_err_o !== 4'b0 || s_cyc_o !== 1'b1) begin miscompares++; $display("FAIL wd_pulse: got to%b err%b cyc%b want 0 0000 1", timeout_o, m_err_o, s_cyc_o); end
        m_cyc = '0; m_stb = '0;
        tick;
        vectors++; if (grant_o !== 4'b0000) begin miscompares++; $display("FAIL wd_idle: got %b want 0000", grant_o); end
    endtask

    task automatic test_ack_on_expiry;
        m_cyc = 4'b0001; m_stb = 4'b0001;
        tick;
        vectors++; if (grant_o !== 4'b0001) begin miscompares++; $display("FAIL ae_grant: got %b want 0001", grant_o); end
        for (int c = 1; c <= 7; c++) tick;
        s_ack_i = 1'b1;
        #1;
        vectors++; if (m_ack_o !== 4'b0001 || m_err_o !== 4'b0 || timeout_o !== 1'b0) begin miscompares++; $display("FAIL ae_ack: got ack%b err%b to%b want 0001 0000 0", m_ack_o, m_err_o, timeout_o); end
        tick;
        s_ack_i = 1'b0;
        #1;
        vectors++; if (s_cyc_o !== 1'b1 || timeout_o !== 1'b0 || m_err_o !== 4'b0 || grant_o !== 4'b0001) begin miscompares++; $display("FAIL ae_noerr: got cyc%b to%b err%b grant%b want 1 0 0000 0001", s_cyc_o, timeout_o, m_err_o, grant_o); end
        // CYC drops in the expiry cycle while STB is still stalled
        for (int c = 1; c <= 7; c++) tick;
        m_cyc = 4'b0000;
        #1;
        vectors++; if (m_err_o !== 4'b0 || timeout_o !== 1'b0) begin miscompares++; $display("FAIL cd_noerr: got err%b to%b want 0000 0", m_err_o, timeout_o); end
        tick;
        vectors++; if (grant_o !== 4'b0000 || timeout_o !== 1'b0 || m_err_o !== 4'b0) begin miscompares++; $display("FAIL cd_idle: got grant%b to%b err%b want 0000 0 0000", grant_o, timeout_o, m_err_o); end
        m_stb = '0;
        tick;
    endtask

    task automatic test_reset_mid;
        m_cyc = 4'b0110; m_stb = 4'b0110;
        tick;
        vectors++; if (grant_o !== 4'b0010) begin miscompares++; $display("FAIL rm_grant: got %b want 0010", grant_o); end
        rst_n = 1'b0; s_ack_i = 1'b1;
        #1;
        vectors++; if (grant_o !== 4'b0000 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin miscompares++; $display("FAIL rm_drop: got grant%b cyc%b stb%b want 0000 0 0", grant_o, s_cyc_o, s_stb_o); end
        vectors++; if (m_ack_o !== 4'b0000 || s_adr_o !== 32'h0) begin miscompares++; $display("FAIL rm_outs: got ack%b adr%h want 0000 0", m_ack_o, s_adr_o); end
        s_ack_i = 1'b0;
        m_cyc = 4'b0111; m_stb = 4'b0111;
        rst_n = 1'b1;
        tick;
        vectors++; if (grant_o !== 4'b0001 || s_adr_o !== adr_tab[0]) begin miscompares++; $display("FAIL rm_first: got %b %h want 0001 %h", grant_o, s_adr_o, adr_tab[0]); end
        m_cyc = '0; m_stb = '0;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end want end");
        $fatal(1, "bench did not finish");
    end

    initial begin
        adr_tab[0] = 32'h0000_1000; adr_tab[1] = 32'h0000_2004;
        adr_tab[2] = 32'h0000_3008; adr_tab[3] = 32'h0000_400C;
        dat_tab[0] = 32'h1111_0000; dat_tab[1] = 32'h2222_0001;
        dat_tab[2] = 32'h3333_0002; dat_tab[3] = 32'h4444_0003;
        sel_tab[0] = 4'hF; sel_tab[1] = 4'h3; sel_tab[2] = 4'hC; sel_tab[3] = 4'h1;
        for (int k = 0; k < 4; k++) begin
            m_adr[k*32 +: 32] = adr_tab[k];
            m_dat[k*32 +: 32] = dat_tab[k];
            m_sel[k*4 +: 4]   = sel_tab[k];
        end
        test_reset;
        test_single_write;
        test_round_robin;
        test_no_preempt;
        test_watchdog;
        test_ack_on_expiry;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
